// File: rtl/mmio_store_port.sv
// -----------------------------------------------------------------------------
// mmio_store_port
//
// Memory-mapped store port sitting on a CPU data bus. Stores that land in the
// TXDATA word of an 8-byte register window are queued in a small FIFO as
// lane-positioned data plus byte-lane enables. A downstream consumer drains
// the FIFO through a valid/ready port. A STATUS register reports the FIFO
// occupancy and a sticky error flag. The error flag is raised by an overflow
// or a misaligned store, and is cleared by writing 1 to STATUS bit 0.
//
// Register window (byte offsets from BASE_ADDR):
//   +0..+3 : TXDATA  (sb at any lane, sh at +0/+2, sw at +0)
//   +4     : STATUS  (lw reads status, sw with bit0=1 clears err)
//   +5..+7 : inside the window (hit asserts) but no register
//
// STATUS read layout:
//   [31:16] 0, [15:8] count, [7:3] 0, [2] err, [1] full, [0] m_valid
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   address     CPU data address
//   write_data  CPU store data
//   sb/sh/sw    store byte / half / word strobes (at most one high)
//   lw          word-load strobe
//   read_data   STATUS value for lw at STATUS, else 0 (combinational)
//   hit         address inside the window with any access strobe high
//   m_valid     head entry available to the drain side
//   m_data      head entry data, lane-positioned (0 when empty)
//   m_strb      head entry byte-lane enables (0 when empty)
//   m_ready     drain side accepts the head entry
//   full        FIFO holds DEPTH entries
//   err         sticky overflow / misaligned-store flag
//
// Drain handshake: the head entry transfers on every rising edge where
// m_valid and m_ready are both 1. m_valid never drops and m_data/m_strb never
// change while an entry is waiting with m_ready low; m_valid does not depend
// on m_ready.
// -----------------------------------------------------------------------------
module mmio_store_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        sb,
    input  logic        sh,
    input  logic        sw,
    input  logic        lw,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic [3:0]  m_strb,
    input  logic        m_ready,
    output logic        full,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [31:0] offset;
    logic        in_window;
    logic        at_txdata;
    logic        at_status;
    logic [1:0]  lane;

    // The offset is unsigned, so addresses below BASE_ADDR wrap to large
    // values and fall outside the window without a second comparison.
    assign offset    = address - BASE_ADDR;
    assign in_window = (offset < 32'd8);
    assign at_txdata = (offset < 32'd4);
    assign at_status = (offset == 32'd4);
    assign lane      = offset[1:0];

    assign hit = in_window && (sb || sh || sw || lw);

    // -------------------------------------------------------------------------
    // Store decode: what would be pushed, or whether the store is misaligned
    // -------------------------------------------------------------------------
    logic        push_req;
    logic [31:0] push_data;
    logic [3:0]  push_strb;
    logic        misalign;
    logic        clear_req;

    always_comb begin
        push_req  = 1'b0;
        push_data = 32'd0;
        push_strb = 4'd0;
        misalign  = 1'b0;
        if (at_txdata) begin
            if (sb) begin
                push_req  = 1'b1;
                push_strb = 4'b0001 << lane;
                push_data = {24'd0, write_data[7:0]} << {lane, 3'b000};
            end else if (sh) begin
                if (lane[0]) begin
                    misalign = 1'b1;
                end else begin
                    push_req = 1'b1;
                    if (lane[1]) begin
                        push_strb = 4'b1100;
                        push_data = {write_data[15:0], 16'd0};
                    end else begin
                        push_strb = 4'b0011;
                        push_data = {16'd0, write_data[15:0]};
                    end
                end
            end else if (sw) begin
                if (lane != 2'd0) begin
                    misalign = 1'b1;
                end else begin
                    push_req  = 1'b1;
                    push_strb = 4'b1111;
                    push_data = write_data;
                end
            end
        end
    end

    // sb/sh to STATUS fall through every branch above and are ignored.
    assign clear_req = sw && at_status && write_data[0];

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          err_q;

    logic          pop;
    logic          overflow;
    logic          do_push;
    logic [CW-1:0] count_next;
    logic          err_next;

    assign m_valid = (count != '0);
    assign full    = (count == DEPTH_C);
    assign err     = err_q;

    assign pop = m_valid && m_ready;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, because that pop frees the slot the push lands in.
    assign overflow = push_req && full && !pop;
    assign do_push  = push_req && !overflow;

    always_comb begin
        count_next = count;
        case ({do_push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Set events win over a clear in the same cycle.
    always_comb begin
        err_next = err_q;
        if (overflow || misalign) begin
            err_next = 1'b1;
        end else if (clear_req) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            err_q <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: not reset; outputs are masked while the FIFO is empty so stale
    // contents never reach the drain side.
    // -------------------------------------------------------------------------
    logic [35:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_strb, push_data};
        end
    end

    logic [35:0] head;

    assign head   = mem[rd_ptr];
    assign m_data = m_valid ? head[31:0]  : 32'd0;
    assign m_strb = m_valid ? head[35:32] : 4'd0;

    // -------------------------------------------------------------------------
    // STATUS read
    // -------------------------------------------------------------------------
    always_comb begin
        read_data = 32'd0;
        if (lw && at_status) begin
            read_data = {16'd0, 8'(count), 5'd0, err_q, full, m_valid};
        end
    end

endmodule

// File: tb/tb_mmio_store_port.sv
// -----------------------------------------------------------------------------
// tb_mmio_store_port
//
// Bench for mmio_store_port with BASE_ADDR = 0x1000 and DEPTH = 8. A queue
// based reference model tracks the FIFO contents and the error flag; one
// compare process checks every DUT output against it at each falling edge.
// Directed sequences pin selected outputs to hand-computed literal values,
// then a randomized phase exercises the window decode, lane placement,
// overflow, clear and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mmio_store_port;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_SB   = 3'd1;
  localparam logic [2:0] OP_SH   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;

  localparam int P_VALID = 0;
  localparam int P_DATA  = 1;
  localparam int P_STRB  = 2;
  localparam int P_FULL  = 3;
  localparam int P_ERR   = 4;
  localparam int P_RD    = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        sb = 1'b0;
  logic        sh = 1'b0;
  logic        sw = 1'b0;
  logic        lw = 1'b0;
  logic [31:0] read_data;
  logic        hit;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic        m_ready = 1'b0;
  logic        full;
  logic        err;

  always #5 clk = ~clk;

  mmio_store_port #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .write_data (write_data),
    .sb         (sb),
    .sh         (sh),
    .sw         (sw),
    .lw         (lw),
    .read_data  (read_data),
    .hit        (hit),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_strb     (m_strb),
    .m_ready    (m_ready),
    .full       (full),
    .err        (err)
  );

  // ---------------------------------------------------------------------------
  // Reference model: queue of {strb, data} entries plus the sticky error bit
  // ---------------------------------------------------------------------------
  logic [35:0] exp_q[$];
  logic        exp_err = 1'b0;

  initial begin
    forever begin : model_step
      logic [31:0] off;
      logic [35:0] ent;
      logic        want;
      logic        bad;
      logic        popn;
      logic        was_full;
      logic        drop;
      int          k;
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        exp_err = 1'b0;
      end else begin
        off  = address - BASE;
        want = 1'b0;
        bad  = 1'b0;
        ent  = 36'd0;
        k    = int'(off[1:0]);
        if (off < 32'd4) begin
          if (sb) begin
            want = 1'b1;
            ent  = {4'(1 << k), 32'(write_data[7:0]) << (8 * k)};
          end else if (sh) begin
            if (k % 2 == 1) bad = 1'b1;
            else begin
              want = 1'b1;
              ent  = {(k == 0) ? 4'b0011 : 4'b1100, 32'(write_data[15:0]) << (8 * k)};
            end
          end else if (sw) begin
            if (k != 0) bad = 1'b1;
            else begin
              want = 1'b1;
              ent  = {4'hF, write_data};
            end
          end
        end
        popn     = (exp_q.size() != 0) && m_ready;
        was_full = (exp_q.size() == DEPTH);
        drop     = want && was_full && !popn;
        if (popn) void'(exp_q.pop_front());
        if (want && !drop) exp_q.push_back(ent);
        if (bad || drop) exp_err = 1'b1;
        else if (sw && off == 32'd4 && write_data[0]) exp_err = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Literal pins set by the directed sequences for the current cycle
  // ---------------------------------------------------------------------------
  logic        pin_en [6];
  logic [31:0] pin_val [6];
  string       pin_name [6] = '{"valid", "data", "strb", "full", "err", "read_data"};

  // ---------------------------------------------------------------------------
  // Scoreboard / compare process (falling edge: inputs and outputs are stable)
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  initial begin
    forever begin : compare_step
      logic [31:0] off;
      logic [35:0] e_head;
      logic        e_valid;
      logic        e_full;
      logic        e_hit;
      logic [31:0] e_rd;
      logic [31:0] act [6];
      logic [31:0] mdl [6];
      int          n;
      @(negedge clk);
      off     = address - BASE;
      n       = exp_q.size();
      e_valid = (n != 0);
      e_full  = (n == DEPTH);
      e_head  = (n != 0) ? exp_q[0] : 36'd0;
      e_hit   = (off < 32'd8) && (sb || sh || sw || lw);
      e_rd    = (lw && off == 32'd4) ? {16'd0, 8'(n), 5'd0, exp_err, e_full, e_valid} : 32'd0;

      chk("hit",       {31'd0, hit},     {31'd0, e_hit});
      chk("m_valid",   {31'd0, m_valid}, {31'd0, e_valid});
      chk("m_data",    m_data,           e_head[31:0]);
      chk("m_strb",    {28'd0, m_strb},  {28'd0, e_head[35:32]});
      chk("full",      {31'd0, full},    {31'd0, e_full});
      chk("err",       {31'd0, err},     {31'd0, exp_err});
      chk("read_data", read_data,        e_rd);

      act[P_VALID] = {31'd0, m_valid};  mdl[P_VALID] = {31'd0, e_valid};
      act[P_DATA]  = m_data;            mdl[P_DATA]  = e_head[31:0];
      act[P_STRB]  = {28'd0, m_strb};   mdl[P_STRB]  = {28'd0, e_head[35:32]};
      act[P_FULL]  = {31'd0, full};     mdl[P_FULL]  = {31'd0, e_full};
      act[P_ERR]   = {31'd0, err};      mdl[P_ERR]   = {31'd0, exp_err};
      act[P_RD]    = read_data;         mdl[P_RD]    = e_rd;
      for (int i = 0; i < 6; i++) begin
        if (pin_en[i]) begin
          chk({"pin_", pin_name[i]}, act[i], pin_val[i]);
          chk({"model_pin_", pin_name[i]}, mdl[i], pin_val[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) pin_en[i] = 1'b0;
    address    = a;
    write_data = wd;
    sb         = (op == OP_SB);
    sh         = (op == OP_SH);
    sw         = (op == OP_SW);
    lw         = (op == OP_LW);
    m_ready    = rdy;
  endtask

  task automatic pin(input int idx, input logic [31:0] v);
    pin_en[idx]  = 1'b1;
    pin_val[idx] = v;
  endtask

  task automatic pin_empty();
    pin(P_VALID, 32'd0);
    pin(P_DATA, 32'd0);
    pin(P_STRB, 32'd0);
    pin(P_FULL, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 6; i++) begin
      pin_en[i]  = 1'b0;
      pin_val[i] = 32'd0;
    end

    // Reset state
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();
    pin(P_ERR, 32'd0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();
    rst = 1'b1;

    // Word store held at the head until accepted
    drive(OP_SW, BASE, 32'hDEAD_BEEF, 1'b0);
    pin(P_VALID, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(OP_NONE, 32'd0, 32'd0, 1'b0);
      pin(P_VALID, 32'd1);
      pin(P_DATA, 32'hDEAD_BEEF);
      pin(P_STRB, 32'hF);
    end
    drive(OP_NONE, 32'd0, 32'd0, 1'b1);
    pin(P_VALID, 32'd1);
    pin(P_DATA, 32'hDEAD_BEEF);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();

    // Byte and halfword lane placement
    drive(OP_SB, BASE + 32'd2, 32'h0000_00AB, 1'b0);
    drive(OP_SH, BASE + 32'd2, 32'h0000_1234, 1'b0);
    pin(P_DATA, 32'h00AB_0000);
    pin(P_STRB, 32'h4);
    drive(OP_NONE, 32'd0, 32'd0, 1'b1);
    pin(P_DATA, 32'h00AB_0000);
    drive(OP_NONE, 32'd0, 32'd0, 1'b1);
    pin(P_DATA, 32'h1234_0000);
    pin(P_STRB, 32'hC);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();

    // Fill to DEPTH, overflow on the ninth store
    for (int i = 0; i < 9; i++) begin
      drive(OP_SW, BASE, 32'h100 + 32'(i), 1'b0);
      if (i == 7) pin(P_FULL, 32'd0);
      if (i == 8) pin(P_FULL, 32'd1);
    end
    drive(OP_LW, BASE + 32'd4, 32'd0, 1'b0);
    pin(P_RD, 32'h0000_0807);   // count 8, err, full, valid
    pin(P_ERR, 32'd1);
    pin(P_DATA, 32'h100);

    // Push and pop together while full
    drive(OP_SW, BASE, 32'hAAAA_5555, 1'b1);
    pin(P_FULL, 32'd1);
    drive(OP_LW, BASE + 32'd4, 32'd0, 1'b0);
    pin(P_RD, 32'h0000_0807);
    pin(P_DATA, 32'h101);
    pin(P_ERR, 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(OP_NONE, 32'd0, 32'd0, 1'b1);
      pin(P_DATA, (i < 7) ? 32'h101 + 32'(i) : 32'hAAAA_5555);
    end
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();
    pin(P_ERR, 32'd1);

    // Clear, misaligned halfword, clear again
    drive(OP_SW, BASE + 32'd4, 32'd1, 1'b0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin(P_ERR, 32'd0);
    drive(OP_SH, BASE + 32'd1, 32'h0000_5678, 1'b0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin(P_ERR, 32'd1);
    pin(P_VALID, 32'd0);
    drive(OP_SW, BASE + 32'd4, 32'd1, 1'b0);
    pin(P_ERR, 32'd1);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin(P_ERR, 32'd0);

    // Asynchronous reset with three entries queued
    drive(OP_SW, BASE, 32'h11, 1'b0);
    drive(OP_SW, BASE, 32'h22, 1'b0);
    drive(OP_SW, BASE, 32'h33, 1'b0);
    drive(OP_LW, BASE + 32'd4, 32'd0, 1'b0);
    pin(P_RD, 32'h0000_0301);
    drive(OP_LW, BASE + 32'd4, 32'd0, 1'b0);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    pin_empty();
    pin(P_RD, 32'd0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    pin_empty();

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin : rnd
      logic [2:0]  op;
      logic [31:0] a;
      logic        rdy;
      int          r;
      op = 3'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 11));
      if (r < 8)       a = BASE + 32'(r);
      else if (r == 8) a = BASE + 32'd8 + 32'($urandom_range(0, 15));
      else if (r == 9) a = BASE - 32'd1 - 32'($urandom_range(0, 3));
      else if (r == 10) a = BASE + 32'd4;
      else             a = $urandom;
      if (it < 750) rdy = ($urandom_range(0, 3) == 0);
      else          rdy = ($urandom_range(0, 3) != 0);
      drive(op, a, $urandom, rdy);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end

    drive(OP_NONE, 32'd0, 32'd0, 1'b1);
    drive(OP_NONE, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
